// File: rtl/mult_rr_scheduler_if.sv
// mult_rr_scheduler_if: request/response bundle between requesters, consumer and the multiplier scheduler
//   req_valid/req_ready : per-requester handshake, req_ready is a one-hot or zero grant
//   req_x/req_y         : packed 4-bit operands, requester i uses [4i+3:4i]
//   rsp_valid/rsp_ready : tagged product handshake
//   rsp_o/rsp_id        : 8-bit product and issuing requester index
//   ops_done            : count of completed response handshakes
interface mult_rr_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [4*N_REQ-1:0] req_x;
    logic [4*N_REQ-1:0] req_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [7:0]         rsp_o;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        ops_done;

    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_o, rsp_id, ops_done
    );

    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_o, rsp_id, ops_done
    );
endinterface

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one 4x4 multiplier with a two-stage tagged result pipeline
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of mult_rr_scheduler_if (requests in, tagged products out, ops_done counter)
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = {4'b0, x} * {4'b0, y};
endmodule

module mult_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    mult_rr_scheduler_if.slave bus
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_valid_q, s1_valid_d;
    logic [3:0]     s1_x_q, s1_x_d;
    logic [3:0]     s1_y_q, s1_y_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [7:0]     rsp_o_q, rsp_o_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [15:0]    ops_done_q, ops_done_d;

    logic           found;
    logic [IDW-1:0] gnt_idx;
    logic [3:0]     sel_x, sel_y;
    int             j;
    logic           s2_load, s1_adv, can_grant, xfer;
    logic [7:0]     prod;

    main u_mul (.x(s1_x_q), .y(s1_y_q), .o(prod));

    // First valid requester at or above ptr, wrapping past N_REQ-1
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sel_x   = '0;
        sel_y   = '0;
        j       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && bus.req_valid[j]) begin
                found   = 1'b1;
                gnt_idx = IDW'(j);
                sel_x   = bus.req_x[4*j +: 4];
                sel_y   = bus.req_y[4*j +: 4];
            end
        end
    end

    assign s2_load   = !rsp_valid_q || bus.rsp_ready;
    assign s1_adv    = s1_valid_q && s2_load;
    // S1 may only accept when it is empty or emptying this cycle
    assign can_grant = !rst && (!s1_valid_q || s1_adv);
    assign xfer      = can_grant && found;

    assign bus.req_ready = xfer ? N_REQ'(1) << gnt_idx : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_o     = rsp_o_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.ops_done  = ops_done_q;

    always_comb begin
        ptr_d       = xfer ? ((gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1)) : ptr_q;
        s1_valid_d  = xfer ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
        s1_x_d      = xfer ? sel_x : s1_x_q;
        s1_y_d      = xfer ? sel_y : s1_y_q;
        s1_id_d     = xfer ? gnt_idx : s1_id_q;
        rsp_valid_d = s2_load ? s1_valid_q : rsp_valid_q;
        // Data only moves on a real advance so it stays put under backpressure
        rsp_o_d     = s1_adv ? prod : rsp_o_q;
        rsp_id_d    = s1_adv ? s1_id_q : rsp_id_q;
        ops_done_d  = ops_done_q + 16'(rsp_valid_q && bus.rsp_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= '0;
            rsp_id_q    <= '0;
            ops_done_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_id_q     <= s1_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_o_q     <= rsp_o_d;
            rsp_id_q    <= rsp_id_d;
            ops_done_q  <= ops_done_d;
        end
    end
endmodule
